// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes: a 128-bit state is substituted LANES bytes per cycle
// through an array of S-box lookups, then offered downstream on valid/ready.

module sbox_lookup (
    input  logic [3:0] row,
    input  logic [3:0] col,
    output logic [7:0] sub
);
    // Rows listed 0..15, so row r lands at index ~r and column c at index ~c.
    localparam logic [15:0][15:0][7:0] TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [15:0][7:0] row_bytes;

    assign row_bytes = TBL[~row];
    assign sub       = row_bytes[~col];
endmodule

module sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    localparam int BEATS = 16 / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

    state_t                  state, state_nxt;
    logic [15:0][7:0]        hold;
    logic [15:0][7:0]        out_b;
    logic [CW-1:0]           beat;
    logic                    last_beat;
    logic [LANES-1:0][3:0]   lane_pos;
    logic [LANES-1:0][7:0]   lane_sub;

    // Byte k of the state sits at packed index ~k (byte 0 is the MSB byte).
    assign last_beat = (beat == CW'(BEATS - 1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_state = out_b;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = SUB;
            SUB:     if (last_beat) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign lane_pos[j] = 4'(int'(beat) * LANES + j);

        sbox_lookup u_sbox (
            .row (hold[~lane_pos[j]][7:4]),
            .col (hold[~lane_pos[j]][3:0]),
            .sub (lane_sub[j])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold  <= '0;
            out_b <= '0;
            beat  <= '0;
        end else begin
            if (state == IDLE && in_valid) begin
                hold <= in_state;
                beat <= '0;
            end
            if (state == SUB) begin
                for (int j = 0; j < LANES; j++)
                    out_b[~lane_pos[j]] <= lane_sub[j];
                // Counter parks at BEATS-1; the next block clears it on acceptance.
                if (!last_beat) beat <= beat + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_sub_bytes_seq.sv
// Directed bench for sub_bytes_seq: three instances (LANES=4, 1, 16) checked
// against hand-computed FIPS-197 S-box results, latencies and handshake corners.

module tb_sub_bytes_seq;
    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] ZERO_IN  = 128'h00000000000000000000000000000000;
    localparam logic [127:0] ZERO_OUT = 128'h63636363636363636363636363636363;
    localparam logic [127:0] ONES_IN  = 128'hffffffffffffffffffffffffffffffff;
    localparam logic [127:0] ONES_OUT = 128'h16161616161616161616161616161616;
    localparam logic [127:0] SEQ_IN   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] SEQ_OUT  = 128'h638293c31bfc33f5c4eeacea4bc12816;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_state  [3];
    logic [127:0] out_state [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Unit 0: LANES=4, unit 1: LANES=1, unit 2: LANES=16.
    for (genvar u = 0; u < 3; u++) begin : g_dut
        sub_bytes_seq #(.LANES(u == 0 ? 4 : (u == 1 ? 1 : 16))) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[u]),
            .in_ready  (in_ready[u]),
            .in_state  (in_state[u]),
            .out_valid (out_valid[u]),
            .out_ready (out_ready[u]),
            .out_state (out_state[u]),
            .busy      (busy[u])
        );
    end

    typedef struct {
        int           u;
        logic [127:0] st;
        logic [127:0] exp;
        int           lat;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one block on unit u, wait for out_valid, capture, then transfer.
    task automatic run(input int u, input logic [127:0] st, output logic [127:0] res, output int lat);
        in_state[u]  = st;
        in_valid[u]  = 1'b1;
        out_ready[u] = 1'b1;
        tick();
        in_valid[u] = 1'b0;
        lat = 0;
        while (!out_valid[u] && lat < 100) begin
            tick();
            lat++;
        end
        res = out_state[u];
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [127:0] res;
        logic [127:0] outs [2];
        int           lat, n, t, nacc, nout;
        int           acct [2];
        logic         acc;

        vt[0] = '{0, FIPS_IN, FIPS_OUT, 4};
        vt[1] = '{1, FIPS_IN, FIPS_OUT, 16};
        vt[2] = '{2, FIPS_IN, FIPS_OUT, 1};
        vt[3] = '{0, ZERO_IN, ZERO_OUT, 4};
        vt[4] = '{0, ONES_IN, ONES_OUT, 4};
        vt[5] = '{0, SEQ_IN,  SEQ_OUT,  4};
        vt[6] = '{2, SEQ_IN,  SEQ_OUT,  1};
        vt[7] = '{1, ZERO_IN, ZERO_OUT, 16};

        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        for (int u = 0; u < 3; u++) in_state[u] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int u = 0; u < 3; u++) begin
            chk($sformatf("rst_in_ready_u%0d", u), in_ready[u], 1);
            chk($sformatf("rst_out_valid_u%0d", u), out_valid[u], 0);
            chk($sformatf("rst_busy_u%0d", u), busy[u], 0);
            chk($sformatf("rst_out_state_u%0d", u), out_state[u], 0);
        end

        for (int i = 0; i < 8; i++) begin
            run(vt[i].u, vt[i].st, res, lat);
            chk($sformatf("vec%0d_data", i), res, vt[i].exp);
            chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
            chk($sformatf("vec%0d_in_ready_after", i), in_ready[vt[i].u], 1);
        end

        // Backpressure: result must hold and no new block may slip in.
        in_state[0]  = FIPS_IN;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b0;
        tick();
        in_valid[0] = 1'b0;
        n = 0;
        while (!out_valid[0] && n < 50) begin
            tick();
            n++;
        end
        chk("bp_latency", n, 4);
        in_valid[0] = 1'b1;
        in_state[0] = ZERO_IN;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("bp_out_valid", out_valid[0], 1);
            chk("bp_out_state", out_state[0], FIPS_OUT);
            chk("bp_in_ready", in_ready[0], 0);
        end
        out_ready[0] = 1'b1;
        tick();
        chk("bp_release_out_valid", out_valid[0], 0);
        chk("bp_release_in_ready", in_ready[0], 1);
        chk("bp_release_busy", busy[0], 0);
        in_valid[0] = 1'b0;
        tick();

        // Input changes during SUB must not affect the captured block.
        in_state[0]  = ZERO_IN;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b1;
        tick();
        n = 0;
        while (!out_valid[0] && n < 50) begin
            in_state[0] = {$urandom, $urandom, $urandom, $urandom};
            in_valid[0] = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        in_valid[0] = 1'b0;
        chk("stable_data", out_state[0], ZERO_OUT);
        chk("stable_latency", n, 4);
        tick();

        // Reset two beats into SUB discards the block.
        in_state[0] = FIPS_IN;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        tick();
        tick();
        chk("midsub_busy_before", busy[0], 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midsub_in_ready", in_ready[0], 1);
        chk("midsub_out_valid", out_valid[0], 0);
        chk("midsub_out_state", out_state[0], 0);
        chk("midsub_busy", busy[0], 0);
        run(0, ZERO_IN, res, lat);
        chk("post_rst_data", res, ZERO_OUT);
        chk("post_rst_latency", lat, 4);

        // Back-to-back with in_valid held high: acceptances BEATS+2 apart.
        in_valid[0]  = 1'b1;
        in_state[0]  = FIPS_IN;
        out_ready[0] = 1'b1;
        t = 0; nacc = 0; nout = 0;
        acct[0] = 0; acct[1] = 0;
        outs[0] = '0; outs[1] = '0;
        while (nout < 2 && t < 60) begin
            acc = in_valid[0] && in_ready[0];
            if (out_valid[0] && out_ready[0]) begin
                outs[nout] = out_state[0];
                nout++;
            end
            tick();
            t++;
            if (acc && nacc < 2) begin
                acct[nacc] = t;
                nacc++;
                if (nacc == 1) in_state[0] = SEQ_IN;
                else           in_valid[0] = 1'b0;
            end
        end
        in_valid[0] = 1'b0;
        chk("b2b_count", nout, 2);
        chk("b2b_first", outs[0], FIPS_OUT);
        chk("b2b_second", outs[1], SEQ_OUT);
        chk("b2b_spacing", acct[1] - acct[0], 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sub_bytes_seq.md
Name: sub_bytes_seq

Overview:
Sequential SubBytes stage for the AES round datapath. Accepts a 128-bit state and pushes it through LANES instances of the existing 4-bit-row/4-bit-column S-box lookup, LANES bytes per cycle. It reassembles the substituted state and hands it downstream to ShiftRows over a valid/ready handshake. LANES trades area (S-box count) against latency.

Parameters:
LANES, 4, number of S-box instances and bytes substituted per cycle; legal values 1, 2, 4, 8, 16. Any other value is an elaboration error.
BEATS, 16/LANES, derived localparam giving the number of substitution cycles per block. Not overridable.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_state is valid
in_ready  output  1  block can accept a state this cycle
in_state  input  128  state to substitute; byte k = bits [8k:8k+7], bit 0 = MSB of byte 0
out_valid  output  1  out_state holds a completed result
out_ready  input  1  downstream accepts out_state this cycle
out_state  output  128  substituted state, same byte ordering as in_state
busy  output  1  high in SUB or DONE

Behaviour:
- Reset (rst high at a clock edge) forces: state=IDLE, in_ready=1, out_valid=0, busy=0, out_state=0, beat counter=0, input holding register=0. Reset wins over every other event, including mid-SUB and an unconsumed DONE; a partially processed block is discarded.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, capture in_state into the holding register, clear beat counter, go to SUB.
  - SUB: in_ready=0. Each cycle, S-box lane j (0..LANES-1) receives byte (beat*LANES + j) of the holding register. Its high nibble drives the row input and its low nibble drives the column input. The lane output is written to the same byte position of out_state. The beat counter increments each cycle. On the cycle the counter reaches BEATS-1, write the last group and go to DONE.
  - DONE: out_valid=1, out_state stable. On out_ready, go to IDLE, clear out_valid, and set in_ready=1 on the next cycle.
- No input acceptance in the DONE→IDLE transition cycle. Throughput is one block per BEATS+2 cycles when out_ready is held high.
- Latency: acceptance at edge T gives out_valid=1 after edge T+BEATS (LANES=4: 4 cycles; LANES=16: 1 cycle).
- out_state bytes not yet written in SUB keep their previous values. Downstream must sample only while out_valid=1.
- Changes to in_state or in_valid outside the acceptance edge have no effect. The holding register is written only on acceptance.
- out_ready while not in DONE is ignored.
- The S-box lookup is purely combinational. All outputs come from registers; there is no combinational path from in_* to out_*.
- The beat counter is ceil(log2(BEATS)) bits, minimum 1. It never wraps within a block because the FSM leaves SUB at BEATS-1.

Test Plan:
- FIPS-197 App. B: in_state=193de3bea0f4e22b9ac68d2ae9f84808, out_ready=1 -> out_state=d42711aee0bf98f1b8b45de51e415230, out_valid exactly BEATS cycles after acceptance (4 at LANES=4). Repeat at LANES=1 (16 cycles) and LANES=16 (1 cycle).
- in_state=all 00 -> all 63. in_state=all ff -> all 16. in_state=00112233445566778899aabbccddeeff -> 638293c31bfc33f5c4eeacea4bc12816.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_valid stays 1, out_state constant, in_ready stays 0, and a new in_valid is not accepted. Release out_ready -> one transfer, then in_ready=1 on the next cycle.
- Back-to-back: drive in_valid continuously with two different states and out_ready=1 -> two correct results in order, second acceptance exactly BEATS+2 cycles after the first.
- Reset mid-SUB: assert rst at beat 2 -> next cycle in_ready=1, out_valid=0, out_state=0. A following all-00 block yields all 63 with normal latency.
- Input stability: toggle in_state every cycle during SUB -> result matches the value captured at acceptance.
